// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED shift controller.
// Contents:
//   MODE_*   - step-mode encodings driven on the mode input
//   state_e  - controller state encoding (ST_IDLE, ST_RUN, ST_PAUSE)
//   rotl8 / rotr8 - single-position 8-bit rotate helpers
package led_ctrl_pkg;

  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] v);
    return {v[0], v[7:1]};
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// wrap cycle. The count is held (not cleared) while disabled.
// Ports:
//   clk  - system clock
//   nrst - asynchronous active-low reset
//   en   - count enable
//   clr  - synchronous clear, overrides en
//   tick - combinational, high in the cycle whose edge wraps the count
module step_prescaler #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_max;

  assign w_at_max = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_at_max) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // A clear in the wrap cycle suppresses the tick so a coincident load wins.
  assign tick = en & ~clr & w_at_max;

endmodule

// File: rtl/led_shift_ctrl.sv
// LED shift/rotate controller: start/stop/pause sequencing of an 8-bit LED
// pattern that rotates left, right, bounces or holds once per prescaled step.
// Ports:
//   clk     - system clock
//   nrst    - asynchronous active-low reset
//   start   - pulse: IDLE->RUN (prescaler cleared) or PAUSE->RUN (resumes)
//   stop    - pulse: RUN->PAUSE; wins over a simultaneous start
//   load    - pulse: led <= pattern, prescaler and bounce direction cleared
//   pattern - value captured on load
//   mode    - 00 left, 01 right, 10 bounce, 11 hold (sampled at each step)
//   led     - registered LED pattern
//   busy    - registered, high while in RUN
//   step    - registered one-cycle pulse, coincident with each led update
module led_shift_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 25000000,
  parameter logic [7:0]  RESET_PATTERN = 8'h01
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [7:0] pattern,
  input  logic [1:0] mode,
  output logic [7:0] led,
  output logic       busy,
  output logic       step
);

  state_e     r_state, w_state_nxt;
  logic [7:0] r_led, w_led_nxt;
  logic       r_dir, w_dir_nxt;
  logic       r_busy;
  logic       r_step;

  logic       w_tick;
  logic       w_pre_en;
  logic       w_pre_clr;
  logic [7:0] w_bounce;

  // Next state. stop dominates start, so start is only honoured without stop.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start && !stop) w_state_nxt = ST_RUN;
      ST_RUN:   if (stop)           w_state_nxt = ST_PAUSE;
      ST_PAUSE: if (start && !stop) w_state_nxt = ST_RUN;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  // Prescaler runs only in RUN; it restarts on entry from IDLE and on load,
  // but a resume from PAUSE continues from the frozen count.
  assign w_pre_en  = (r_state == ST_RUN);
  assign w_pre_clr = load | ((r_state == ST_IDLE) & start & ~stop);

  step_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .nrst (nrst),
    .en   (w_pre_en),
    .clr  (w_pre_clr),
    .tick (w_tick)
  );

  assign w_bounce = r_dir ? rotr8(r_led) : rotl8(r_led);

  // LED and bounce-direction update. load takes priority over a step.
  always_comb begin
    w_led_nxt = r_led;
    w_dir_nxt = r_dir;
    if (load) begin
      w_led_nxt = pattern;
      w_dir_nxt = 1'b0;
    end else if (w_tick) begin
      unique case (mode)
        MODE_LEFT:   w_led_nxt = rotl8(r_led);
        MODE_RIGHT:  w_led_nxt = rotr8(r_led);
        MODE_BOUNCE: begin
          w_led_nxt = w_bounce;
          // Turn around when the moving edge reaches the end it travels to.
          if (!r_dir && w_bounce[7]) begin
            w_dir_nxt = 1'b1;
          end else if (r_dir && w_bounce[0]) begin
            w_dir_nxt = 1'b0;
          end
        end
        MODE_HOLD:   w_led_nxt = r_led;
        default:     w_led_nxt = r_led;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_led   <= RESET_PATTERN;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_dir   <= w_dir_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      // w_tick is already suppressed by load.
      r_step  <= w_tick;
    end
  end

  assign led  = r_led;
  assign busy = r_busy;
  assign step = r_step;

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Directed bench for led_shift_ctrl with TICK_DIV=4. Expected steps (cycle
// and LED value) are queued when stimulus is driven and checked by a monitor
// whenever the DUT pulses step.
module tb_led_shift_ctrl;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       load = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [1:0] mode = 2'b00;
  logic [7:0] led;
  logic       busy;
  logic       step;

  led_shift_ctrl #(
    .TICK_DIV      (4),
    .RESET_PATTERN (8'h01)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .start   (start),
    .stop    (stop),
    .load    (load),
    .pattern (pattern),
    .mode    (mode),
    .led     (led),
    .busy    (busy),
    .step    (step)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic [7:0]  val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int unsigned at, input logic [7:0] v);
    exp_t e;
    e.at  = at;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every step pulse must match the next queued entry.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_step", {31'b0, step}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("step_cycle", cyc, e.at);
        chk("step_led", {24'b0, led}, {24'b0, e.val});
      end
    end
  end

  logic [7:0]  bounce_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                   8'h02};
  int unsigned s;
  int unsigned r;

  initial begin
    // Reset
    #2 nrst = 1'b0;
    tick_n(2);
    chk("reset_led", {24'b0, led}, 32'h01);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_step", {31'b0, step}, 32'd0);
    nrst = 1'b1;
    tick_n(1);

    // start+stop together in IDLE: nothing happens
    start = 1'b1; stop = 1'b1;
    tick_n(1);
    start = 1'b0; stop = 1'b0;
    chk("conflict_busy", {31'b0, busy}, 32'd0);
    tick_n(6);
    chk("conflict_busy_later", {31'b0, busy}, 32'd0);
    chk("conflict_led", {24'b0, led}, 32'h01);

    // Rotate left from 8'h81
    pattern = 8'h81; mode = 2'b00; load = 1'b1;
    tick_n(1);
    load = 1'b0;
    chk("load_led", {24'b0, led}, 32'h81);
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    s = cyc;
    chk("left_busy", {31'b0, busy}, 32'd1);
    push_exp(s + 4, 8'h03);
    push_exp(s + 8, 8'h06);
    push_exp(s + 12, 8'h0C);
    tick_n(12);
    stop = 1'b1;
    tick_n(1);
    stop = 1'b0;
    chk("stop_busy", {31'b0, busy}, 32'd0);

    // Rotate right from 8'h01 (load in PAUSE clears the prescaler)
    pattern = 8'h01; mode = 2'b01; load = 1'b1;
    tick_n(1);
    load = 1'b0;
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    s = cyc;
    push_exp(s + 4, 8'h80);
    push_exp(s + 8, 8'h40);
    tick_n(8);
    stop = 1'b1;
    tick_n(1);
    stop = 1'b0;

    // Bounce, 15 steps
    pattern = 8'h01; mode = 2'b10; load = 1'b1;
    tick_n(1);
    load = 1'b0;
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    s = cyc;
    for (int i = 0; i < 15; i++) push_exp(s + 4 * (i + 1), bounce_seq[i]);
    tick_n(60);
    stop = 1'b1;
    tick_n(1);
    stop = 1'b0;

    // Pause two cycles into a period, resume after 10 cycles
    pattern = 8'h01; mode = 2'b00; load = 1'b1;
    tick_n(1);
    load = 1'b0;
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    s = cyc;
    push_exp(s + 4, 8'h02);
    tick_n(5);
    stop = 1'b1;
    tick_n(1);
    stop = 1'b0;
    chk("pause_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick_n(1);
      chk("pause_led", {24'b0, led}, 32'h02);
      chk("pause_busy_hold", {31'b0, busy}, 32'd0);
    end
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    r = cyc;
    chk("resume_busy", {31'b0, busy}, 32'd1);
    push_exp(r + 2, 8'h04);
    push_exp(r + 6, 8'h08);
    tick_n(6);

    // load 8'hA5 coincident with the step at r+10: load wins, no pulse
    tick_n(3);
    pattern = 8'hA5; load = 1'b1;
    tick_n(1);
    load = 1'b0;
    chk("load_on_step_led", {24'b0, led}, 32'hA5);
    chk("load_on_step_nostep", {31'b0, step}, 32'd0);
    push_exp(r + 14, 8'h4B);
    push_exp(r + 18, 8'h96);
    tick_n(8);

    // Hold mode: step keeps pulsing, led constant
    mode = 2'b11;
    push_exp(r + 22, 8'h96);
    push_exp(r + 26, 8'h96);
    tick_n(8);
    chk("hold_led", {24'b0, led}, 32'h96);

    // Asynchronous reset mid-run
    tick_n(2);
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_led", {24'b0, led}, 32'h01);
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_step", {31'b0, step}, 32'd0);
    tick_n(3);
    nrst = 1'b1;
    tick_n(8);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_led", {24'b0, led}, 32'h01);
    chk("pending_steps", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_shift_ctrl.md
# led_shift_ctrl

Controller that sequences the 8-bit LED shift/rotate datapath. It generates the step rate from the system clock, loads a user pattern, and runs, pauses or stops the display. It moves the pattern left, right or ping-pong (bounce) once per step. It sits between the board keys/switches and the LED pins, and replaces free-running rotation with a start/stop-controlled sequence.

## Interface
- `TICK_DIV`, default 25000000: clock cycles per LED step; legal range ≥ 2.
- `RESET_PATTERN`, default 8'h01: LED value after reset.
- `clk  in  1`: system clock, 50 MHz on board.
- `nrst  in  1`: reset, asynchronous, active-low.
- `start  in  1`: single-cycle pulse; begins or resumes stepping.
- `stop  in  1`: single-cycle pulse; pauses stepping.
- `load  in  1`: single-cycle pulse; captures `pattern` into the LED register.
- `pattern  in  8`: value loaded on `load`.
- `mode  in  2`: 00 rotate left, 01 rotate right, 10 bounce, 11 hold.
- `led  out  8`: registered LED pattern.
- `busy  out  1`: registered; 1 while in RUN.
- `step  out  1`: registered one-cycle pulse on each step edge.

## Operation
- States: IDLE, RUN, PAUSE. Reset enters IDLE.
- IDLE → RUN on `start`. The prescaler clears on entry.
- RUN → PAUSE on `stop`. The prescaler value is frozen, not cleared.
- PAUSE → RUN on `start`. Counting resumes from the frozen value.
- `stop` in IDLE or PAUSE: no effect. `start` in RUN: no effect.
- Simultaneous `start` and `stop`: `stop` wins. From IDLE or PAUSE, no transition occurs.
- Prescaler: counts 0..TICK_DIV-1, only in RUN. At TICK_DIV-1 it wraps to 0 and produces a step.
- Step by mode:
  - Rotate left: `{led[6:0],led[7]}`.
  - Rotate right: `{led[0],led[7:1]}`.
  - Hold: `led` unchanged, but `step` still pulses.
- Bounce:
  - Direction register `dir`: 0 = left, 1 = right.
  - Each step rotates in direction `dir`.
  - If the new value has bit7 set and `dir`=0, `dir` becomes 1.
  - If the new value has bit0 set and `dir`=1, `dir` becomes 0.
  - 8'hFF therefore flips `dir` on every step; 8'h00 never changes. Both are legal.
- `dir` clears to 0 on reset and on `load`. It persists across mode changes.
- `mode` is sampled at each step. A change mid-period applies at the next step.
- `load`, accepted in any state:
  - `led` ← `pattern`, the prescaler clears, `dir` ← 0.
  - The state is unchanged.
- `load` coincident with a step: `load` wins. No rotation occurs and `step` stays 0.
- `load` coincident with `start`/`stop`: both take effect.

## Timing
- Reset values:
  - `led` = RESET_PATTERN
  - `busy` = 0, `step` = 0
  - state IDLE, prescaler 0, `dir` 0
- All outputs are registered. `step` is asserted in the same cycle `led` shows the new value.
- First step occurs TICK_DIV cycles after the `start` edge, when starting from IDLE or after a `load`.
- `busy` rises the cycle after the `start` edge and falls the cycle after the `stop` edge.
- `load` makes `led` = `pattern` on the cycle after the `load` edge.
- `nrst` asserted mid-run: all state returns to reset values immediately, without a clock edge.

## Structure
- Package `led_ctrl_pkg` holds:
  - the mode encoding constants (MODE_LEFT, MODE_RIGHT, MODE_BOUNCE, MODE_HOLD);
  - the state encoding (ST_IDLE, ST_RUN, ST_PAUSE).
- Sub-module `step_prescaler`:
  - parameter TICK_DIV;
  - inputs `en`, `clr`; output `tick`;
  - counter width is $clog2(TICK_DIV).
- The FSM, the LED register and the bounce `dir` register live in the top module.

## Test plan
All cases use TICK_DIV=4.
- Left rotate: load 8'h81, mode 00, start → `step` pulses every 4 cycles; `led` goes 8'h03, 8'h06, 8'h0C.
- Right rotate: load 8'h01, mode 01, start → first step gives `led`=8'h80, then 8'h40.
- Bounce: load 8'h01, mode 10, start, run 15 steps → `led` goes 02,04,…,80,40,…,01,02.
- Pause/resume:
  - Sequence: start, `stop` 2 cycles into a period, wait 10 cycles, `start`.
  - Required: `led` and prescaler frozen during the pause; `busy`=0 while paused; next step 2 cycles after resume.
- Conflicts:
  - `start` and `stop` in the same cycle in IDLE → stays IDLE, `busy`=0.
  - `load` 8'hA5 on a step cycle → `led`=8'hA5, no `step` pulse, next step 4 cycles later.
- Reset/hold:
  - mode 11 → `step` pulses while `led` is constant.
  - `nrst` low mid-run → `led`=8'h01, `busy`=0, `step`=0 immediately.
